// File: rtl/regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter
//
// Shares the regfile's single write port and single read port between NUM_REQ
// requesters (for example the AXI4-Lite slave and the PWM sequencer). Each
// request is a read or a write and receives exactly one single-cycle response
// pulse. Concurrent requests are arbitrated round-robin.
//
// Transaction flow: IDLE -> ACCESS (one cycle, regfile port driven) -> RESP
// (one cycle, rsp_valid pulse) -> IDLE.
//
// Handshake: a requester raises req[i] with req_wr/req_addr/req_wdata and
// holds them stable until it observes rsp_valid[i]; it must drop req[i] in the
// cycle after rsp_valid. A req still high when the block is back in IDLE is a
// new request. Fields of a request that is not yet granted are only looked at
// when it is granted.
//
// Configuration macro:
//   REGFILE_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                           no round-robin pointer.
//                              undefined -> round-robin (default).
//
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   req             per-requester request valid
//   req_wr          per-requester 1 = write, 0 = read
//   req_addr        flattened addresses, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata       flattened write data, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid       one-cycle response pulse to the granted requester
//   rsp_rdata       read data, valid only while rsp_valid is high (0 for writes)
//   busy            high in every state except IDLE
//   rf_write_en     regfile write enable (ACCESS cycle of a write only)
//   rf_write_addr   regfile write address
//   rf_write_data   regfile write data
//   rf_read_addr    regfile read address
//   rf_read_data    regfile read data (combinational from rf_read_addr)
// -----------------------------------------------------------------------------
module regfile_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          busy,
  output logic                          rf_write_en,
  output logic [ADDR_WIDTH-1:0]         rf_write_addr,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic [ADDR_WIDTH-1:0]         rf_read_addr,
  input  logic [DATA_WIDTH-1:0]         rf_read_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  // Registered outputs
  logic                    rf_write_en_q, rf_write_en_d;
  logic [ADDR_WIDTH-1:0]   rf_write_addr_q, rf_write_addr_d;
  logic [DATA_WIDTH-1:0]   rf_write_data_q, rf_write_data_d;
  logic [ADDR_WIDTH-1:0]   rf_read_addr_q, rf_read_addr_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    busy_q, busy_d;

  // Arbitration
  logic [PTR_W-1:0]        search_base;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_found;
  int                      cand;

  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign search_base = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign search_base = ptr_q;

  // Pointer moves to the requester just after the one granted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && pick_found) begin
      ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Search upward from search_base with wrap-around; first active req wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(search_base) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
  end

  // Fields of the winning requester
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and latched request
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_ACCESS;
          grant_d = pick_idx;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output values for the cycle that follows, derived from the next state so
  // the outputs themselves come straight from flops.
  always_comb begin
    rf_write_en_d   = 1'b0;
    rf_write_addr_d = '0;
    rf_write_data_d = '0;
    rf_read_addr_d  = '0;
    rsp_valid_d     = '0;
    rsp_rdata_d     = '0;
    busy_d          = (state_d != ST_IDLE);
    if (state_d == ST_ACCESS) begin
      rf_read_addr_d = addr_d;
      if (wr_d) begin
        rf_write_en_d   = 1'b1;
        rf_write_addr_d = addr_d;
        rf_write_data_d = wdata_d;
      end
    end
    if (state_d == ST_RESP) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid_d[i] = (grant_d == PTR_W'(i));
      end
      // Read data is captured at the end of ACCESS; writes answer with 0.
      rsp_rdata_d = wr_q ? '0 : rf_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rf_write_en_q   <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      rf_read_addr_q  <= '0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
      rf_read_addr_q  <= rf_read_addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      busy_q          <= busy_d;
    end
  end

  // Reset is synchronous, so a reset asserted in the middle of ACCESS or RESP
  // only clears the flops at the next edge. Masking the two side-effecting
  // outputs with rst_n keeps the regfile from committing the abandoned write
  // on that edge and suppresses the abandoned response pulse.
  assign rf_write_en   = rf_write_en_q & rst_n;
  assign rsp_valid     = rsp_valid_q & {NUM_REQ{rst_n}};
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_read_addr  = rf_read_addr_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;

endmodule
